rvb_xperm_seq: RTL and testbench

Sequencing stage directly upstream of the bitmanip crossbar-permutation unit (`rvb_xperm`). It accepts a decoded-stage instruction word plus operands over a valid/ready handshake and recognises Zbkx `xperm4` (nibble) and `xperm8` (byte). It drives the permutation unit's operand and select inputs with a clean `xperm_valid` rising edge, waits a configurable settle time, captures the result, and hands it to writeback over a second valid/ready handshake. Any other instruction is flagged illegal without touching the permutation unit.

---
 rtl/rvb_xperm_seq_pkg.sv | 19 +
 rtl/rvb_xperm_decode.sv | 21 ++
 rtl/rvb_xperm_seq.sv | 143 ++++++++++++++
 tb/tb_rvb_xperm_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvb_xperm_seq_pkg.sv
// Shared bitmanip definitions for the Zbkx crossbar-permutation sequencer:
// decode constants, FSM encoding and settle-counter width.
package rvb_xperm_seq_pkg;

   localparam logic [31:0] XPERM_MASK   = 32'hFE00707F;
   localparam logic [31:0] XPERM4_MATCH = 32'h28002033;
   localparam logic [31:0] XPERM8_MATCH = 32'h28004033;

   localparam int unsigned CNT_W = 4;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/rvb_xperm_decode.sv
// Combinational Zbkx decoder: classifies an instruction word as xperm4,
// xperm8 or illegal.
module rvb_xperm_decode
   import rvb_xperm_seq_pkg::*;
(
   input  logic [31:0] insn,
   output logic        is_xperm_n,
   output logic        is_xperm_b,
   output logic        illegal
);

   logic [31:0] masked;

   always_comb begin
      masked     = insn & XPERM_MASK;
      is_xperm_n = (masked == XPERM4_MATCH);
      is_xperm_b = (masked == XPERM8_MATCH);
      illegal    = ~(is_xperm_n | is_xperm_b);
   end

endmodule

// File: rtl/rvb_xperm_seq.sv
// Sequencer in front of the rvb_xperm crossbar unit: accepts a decoded
// instruction, drives the unit for a settle window and returns its result.
module rvb_xperm_seq
   import rvb_xperm_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
)
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_insn,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [4:0]  in_rd,
   output logic        xperm_valid,
   output logic        op_xperm_n,
   output logic        op_xperm_b,
   output logic [31:0] xp_rs1,
   output logic [31:0] xp_rs2,
   input  logic [31:0] xp_res,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_illegal,
   output logic        busy
);

   localparam cnt_t CNT_LOAD = cnt_t'(SETTLE_CYCLES - 1);

   state_e      state_q, state_d;
   cnt_t        cnt_q, cnt_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] rs2_q, rs2_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  rd_q, rd_d;
   logic        op_n_q, op_n_d;
   logic        op_b_q, op_b_d;
   logic        illegal_q, illegal_d;

   logic        dec_n, dec_b, dec_ill;

   rvb_xperm_decode u_decode (
      .insn       (in_insn),
      .is_xperm_n (dec_n),
      .is_xperm_b (dec_b),
      .illegal    (dec_ill)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         data_q    <= '0;
         rd_q      <= '0;
         op_n_q    <= 1'b0;
         op_b_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         data_q    <= data_d;
         rd_q      <= rd_d;
         op_n_q    <= op_n_d;
         op_b_q    <= op_b_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (in_valid) state_d = dec_ill ? ST_DONE : ST_DRIVE;
         ST_DRIVE: state_d = ST_WAIT;
         ST_WAIT:  if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      data_d    = data_q;
      rd_d      = rd_q;
      op_n_d    = op_n_q;
      op_b_d    = op_b_q;
      illegal_d = illegal_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               rd_d = in_rd;
               if (dec_ill) begin
                  illegal_d = 1'b1;
                  data_d    = '0;
                  op_n_d    = 1'b0;
                  op_b_d    = 1'b0;
               end else begin
                  illegal_d = 1'b0;
                  rs1_d     = in_rs1;
                  rs2_d     = in_rs2;
                  op_n_d    = dec_n;
                  op_b_d    = dec_b;
                  cnt_d     = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            // Selects drop on the capture edge so they already read 0 back in IDLE
            if (cnt_q == '0) begin
               data_d = xp_res;
               op_n_d = 1'b0;
               op_b_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready    = (state_q == ST_IDLE);
      busy        = (state_q != ST_IDLE);
      xperm_valid = (state_q == ST_DRIVE) || (state_q == ST_WAIT);
      out_valid   = (state_q == ST_DONE);
      op_xperm_n  = op_n_q;
      op_xperm_b  = op_b_q;
      xp_rs1      = rs1_q;
      xp_rs2      = rs2_q;
      out_data    = data_q;
      out_rd      = rd_q;
      out_illegal = illegal_q;
   end

endmodule

// File: tb/tb_rvb_xperm_seq.sv
// Directed bench for rvb_xperm_seq: table of xperm4/xperm8/illegal vectors
// plus hand sequences for backpressure, a long settle window and reset.
module tb_rvb_xperm_seq;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_valid4;
   logic [31:0] in_insn, in_rs1, in_rs2;
   logic [4:0]  in_rd;
   logic        out_ready;

   logic        in_ready, xperm_valid, op_xperm_n, op_xperm_b, out_valid, out_illegal, busy;
   logic [31:0] xp_rs1, xp_rs2, xp_res, out_data;
   logic [4:0]  out_rd;

   logic        in_ready4, xperm_valid4, op_xperm_n4, op_xperm_b4, out_valid4, out_illegal4, busy4;
   logic [31:0] xp_rs1_4, xp_rs2_4, xp_res4, out_data4;
   logic [4:0]  out_rd4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behavioural crossbar: out-of-range indices yield zero
   function automatic logic [31:0] xperm_ref(input logic [31:0] a, input logic [31:0] b,
                                             input logic byte_mode);
      logic [31:0] r;
      int idx;
      r = '0;
      if (byte_mode) begin
         for (int i = 0; i < 4; i++) begin
            idx = int'(b[8*i +: 8]);
            if (idx < 4) r[8*i +: 8] = a[8*idx +: 8];
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            idx = int'(b[4*i +: 4]);
            if (idx < 8) r[4*i +: 4] = a[4*idx +: 4];
         end
      end
      return r;
   endfunction

   assign xp_res  = xperm_valid  ? xperm_ref(xp_rs1,   xp_rs2,   op_xperm_b)  : 32'hDEADBEEF;
   assign xp_res4 = xperm_valid4 ? xperm_ref(xp_rs1_4, xp_rs2_4, op_xperm_b4) : 32'hDEADBEEF;

   rvb_xperm_seq dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_insn(in_insn), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .xperm_valid(xperm_valid), .op_xperm_n(op_xperm_n), .op_xperm_b(op_xperm_b),
      .xp_rs1(xp_rs1), .xp_rs2(xp_rs2), .xp_res(xp_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_illegal(out_illegal), .busy(busy)
   );

   rvb_xperm_seq #(.SETTLE_CYCLES(4)) dut4 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_insn(in_insn), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .xperm_valid(xperm_valid4), .op_xperm_n(op_xperm_n4), .op_xperm_b(op_xperm_b4),
      .xp_rs1(xp_rs1_4), .xp_rs2(xp_rs2_4), .xp_res(xp_res4),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .out_rd(out_rd4), .out_illegal(out_illegal4), .busy(busy4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request to the default-settle DUT and wait for out_valid.
   // lat is the cycle index of out_valid (acceptance = cycle 0).
   task automatic run_op(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, output int lat, output int xv);
      @(negedge clk);
      chk("in_ready_before_req", 32'(in_ready), 32'd1);
      in_insn  = insn;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_rd    = rd;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_insn  = '0;
      in_rs1   = ~rs1;
      in_rs2   = ~rs2;
      in_rd    = ~rd;
      lat = 0;
      xv  = 0;
      do begin
         @(negedge clk);
         lat++;
         if (xperm_valid) xv++;
      end while (!out_valid && lat < 40);
   endtask

   task automatic finish_op();
      @(posedge clk);
      @(negedge clk);
      chk("post_xfer_out_valid", 32'(out_valid), 32'd0);
      chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
      chk("post_xfer_busy", 32'(busy), 32'd0);
      chk("post_xfer_selects", 32'({op_xperm_n, op_xperm_b}), 32'd0);
   endtask

   typedef struct {
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [31:0] exp_data;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat, xv, rises, high, ovs, first_ov, rise1, rise2;
      logic prev;

      vecs[0] = '{32'h2820A1B3, 32'h76543210, 32'h01234567, 5'd3,  32'h01234567, 1'b0};
      vecs[1] = '{32'h2820A1B3, 32'hFEDCBA98, 32'h89ABCDE7, 5'd7,  32'h0000000F, 1'b0};
      vecs[2] = '{32'h2820C1B3, 32'h44332211, 32'h00010203, 5'd5,  32'h11223344, 1'b0};
      vecs[3] = '{32'h2820C1B3, 32'h44332211, 32'h000000FF, 5'd6,  32'h11111100, 1'b0};
      vecs[4] = '{32'h2820C033, 32'hAABBCCDD, 32'h03020100, 5'd0,  32'hAABBCCDD, 1'b0};
      vecs[5] = '{32'h00000033, 32'h12345678, 32'h9ABCDEF0, 5'd11, 32'h00000000, 1'b1};
      vecs[6] = '{32'h2A00A1B3, 32'h76543210, 32'h01234567, 5'd12, 32'h00000000, 1'b1};
      vecs[7] = '{32'h2820E1B3, 32'h76543210, 32'h01234567, 5'd31, 32'h00000000, 1'b1};

      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_valid4 = 1'b0;
      in_insn   = '0;
      in_rs1    = '0;
      in_rs2    = '0;
      in_rd     = '0;
      out_ready = 1'b1;

      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_xperm_valid", 32'(xperm_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_xp_rs1", xp_rs1, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].insn, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, lat, xv);
         chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exp_ill ? 32'd1 : 32'd3);
         chk($sformatf("v%0d_xperm_valid_cycles", i), 32'(xv), vecs[i].exp_ill ? 32'd0 : 32'd2);
         chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
         chk($sformatf("v%0d_out_rd", i), 32'(out_rd), 32'(vecs[i].rd));
         chk($sformatf("v%0d_out_illegal", i), 32'(out_illegal), 32'(vecs[i].exp_ill));
         if (vecs[i].exp_ill)
            chk($sformatf("v%0d_illegal_selects", i), 32'({op_xperm_n, op_xperm_b}), 32'd0);
         finish_op();
      end

      // Backpressure in DONE
      out_ready = 1'b0;
      run_op(32'h2820C1B3, 32'h44332211, 32'h00010203, 5'd9, lat, xv);
      chk("hold_latency", 32'(lat), 32'd3);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_out_data", out_data, 32'h11223344);
         chk("hold_out_rd", 32'(out_rd), 32'd9);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      finish_op();

      // SETTLE_CYCLES=4, two back-to-back ops with in_valid held high
      @(negedge clk);
      in_insn   = 32'h2820A1B3;
      in_rs1    = 32'h76543210;
      in_rs2    = 32'h01234567;
      in_rd     = 5'd4;
      in_valid4 = 1'b1;
      prev = 1'b0; rises = 0; high = 0; ovs = 0; first_ov = 0; rise1 = 0; rise2 = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 9) in_valid4 = 1'b0;
         if (xperm_valid4 && !prev) begin
            rises++;
            if (rises == 1) rise1 = c;
            if (rises == 2) rise2 = c;
         end
         if (xperm_valid4) high++;
         if (out_valid4) begin
            ovs++;
            if (first_ov == 0) first_ov = c;
            chk("s4_out_data", out_data4, 32'h01234567);
         end
         prev = xperm_valid4;
      end
      chk("s4_first_out_valid_cycle", 32'(first_ov), 32'd6);
      chk("s4_xperm_rises", 32'(rises), 32'd2);
      chk("s4_first_rise", 32'(rise1), 32'd1);
      chk("s4_op_spacing", 32'(rise2 - rise1), 32'd7);
      chk("s4_xperm_high_cycles", 32'(high), 32'd10);
      chk("s4_out_valid_cycles", 32'(ovs), 32'd2);

      // Reset during WAIT
      @(negedge clk);
      in_insn  = 32'h2820A1B3;
      in_rs1   = 32'h76543210;
      in_rs2   = 32'h01234567;
      in_rd    = 5'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_xperm_valid", 32'(xperm_valid), 32'd1);
      resetn = 1'b0;
      #1;
      chk("midrst_xperm_valid", 32'(xperm_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      chk("midrst_out_rd", 32'(out_rd), 32'd0);
      chk("midrst_xp_rs2", xp_rs2, 32'd0);
      chk("midrst_selects", 32'({op_xperm_n, op_xperm_b}), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      ovs = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) ovs++;
      end
      chk("aborted_no_out_valid", 32'(ovs), 32'd0);
      run_op(32'h2820C1B3, 32'h44332211, 32'h000000FF, 5'd2, lat, xv);
      chk("post_rst_latency", 32'(lat), 32'd3);
      chk("post_rst_out_data", out_data, 32'h11111100);
      chk("post_rst_out_rd", 32'(out_rd), 32'd2);
      finish_op();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
